// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and defaults for the data-memory arbiter
// Contents: FSM state encoding, owner ID encoding, decode defaults and the
// one-hot target select struct used by addr_decode and the arbiter datapath.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam int         PER_BIT_DEF  = 30;
  localparam logic [7:0] TM_LIMIT_DEF = 8'h15;

  // One-hot target select: data memory, timer, UART.
  typedef struct packed {
    logic dm;
    logic tm;
    logic um;
  } sel_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, target and read-return signals of the arbiter
// Ports (slave = arbiter side):
//   cpu_req/cpu_wr/cpu_addr/cpu_wdata -> in,  cpu_gnt/cpu_rvalid -> out
//   dma_req/dma_wr/dma_addr/dma_wdata -> in,  dma_gnt/dma_rvalid -> out
//   rdata, bus_addr, bus_wdata        -> out (shared read return, access in flight)
//   dm/tm/um _rd/_wr                   -> out (one-cycle target strobes)
//   dm_data/tm_data/um_data            -> in  (target read data, valid in strobe cycle)
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;

  logic        dma_req;
  logic        dma_wr;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;

  logic [31:0] rdata;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;

  logic        dm_rd;
  logic        dm_wr;
  logic        tm_rd;
  logic        tm_wr;
  logic        um_rd;
  logic        um_wr;

  logic [31:0] dm_data;
  logic [31:0] tm_data;
  logic [31:0] um_data;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    input  dm_data, tm_data, um_data,
    output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
    output rdata, bus_addr, bus_wdata,
    output dm_rd, dm_wr, tm_rd, tm_wr, um_rd, um_wr
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    output dm_data, tm_data, um_data,
    input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
    input  rdata, bus_addr, bus_wdata,
    input  dm_rd, dm_wr, tm_rd, tm_wr, um_rd, um_wr
  );
endinterface

// File: rtl/dmem_arbiter_addr_decode.sv
// rtl/dmem_arbiter_addr_decode.sv - byte address to data memory / timer / UART select
// Ports: i_addr (32, in) byte address; o_sel (sel_t, out) one-hot target select.
module addr_decode
  import dmem_arbiter_pkg::*;
#(
  parameter int         PER_BIT  = PER_BIT_DEF,
  parameter logic [7:0] TM_LIMIT = TM_LIMIT_DEF
) (
  input  logic [31:0] i_addr,
  output sel_t        o_sel
);

  // Only PER_BIT and the low byte take part in decode.
  logic w_unused_bits;
  assign w_unused_bits = ^i_addr;

  always_comb begin
    o_sel = '0;
    if (!i_addr[PER_BIT]) begin
      o_sel.dm = 1'b1;
    end else if (i_addr[7:0] < TM_LIMIT) begin
      o_sel.tm = 1'b1;
    end else begin
      o_sel.um = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin CPU/DMA arbiter onto data memory, timer and UART
// Ports: clk (in) rising-edge clock; reset (in) synchronous active-high;
//   bus (dmem_arbiter_if.slave) requester handshakes, target strobes and read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int         PER_BIT  = PER_BIT_DEF,
  parameter logic [7:0] TM_LIMIT = TM_LIMIT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  owner_t      r_ptr;
  owner_t      r_owner;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_cpu_gnt, r_dma_gnt;
  logic        r_cpu_rvalid, r_dma_rvalid;
  logic        r_dm_rd, r_dm_wr, r_tm_rd, r_tm_wr, r_um_rd, r_um_wr;

  logic        w_cpu_gnt_nxt, w_dma_gnt_nxt;
  logic        w_cpu_rvalid_nxt, w_dma_rvalid_nxt;
  logic        w_dm_rd_nxt, w_dm_wr_nxt, w_tm_rd_nxt, w_tm_wr_nxt, w_um_rd_nxt, w_um_wr_nxt;
  logic        w_take;
  logic        w_capture;

  owner_t      w_win;
  logic        w_win_wr;
  logic [31:0] w_win_addr;
  logic [31:0] w_win_wdata;
  sel_t        w_win_sel;
  sel_t        w_bus_sel;
  logic [31:0] w_rd_mux;

  // On a tie the requester that did not own the bus last time wins.
  always_comb begin
    if (bus.cpu_req && bus.dma_req) begin
      w_win = (r_ptr == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (bus.cpu_req) begin
      w_win = OWN_CPU;
    end else begin
      w_win = OWN_DMA;
    end
  end

  assign w_win_wr    = (w_win == OWN_CPU) ? bus.cpu_wr    : bus.dma_wr;
  assign w_win_addr  = (w_win == OWN_CPU) ? bus.cpu_addr  : bus.dma_addr;
  assign w_win_wdata = (w_win == OWN_CPU) ? bus.cpu_wdata : bus.dma_wdata;

  // Strobes are registered, so the winner's address is decoded one cycle
  // early; it becomes bus_addr in the same edge.
  addr_decode #(.PER_BIT(PER_BIT), .TM_LIMIT(TM_LIMIT)) u_win_dec (
    .i_addr (w_win_addr),
    .o_sel  (w_win_sel)
  );

  // Read-return source for the access in flight, used during ISSUE.
  addr_decode #(.PER_BIT(PER_BIT), .TM_LIMIT(TM_LIMIT)) u_bus_dec (
    .i_addr (r_addr),
    .o_sel  (w_bus_sel)
  );

  always_comb begin
    w_rd_mux = '0;
    if (w_bus_sel.dm) begin
      w_rd_mux = bus.dm_data;
    end else if (w_bus_sel.tm) begin
      w_rd_mux = bus.tm_data;
    end else if (w_bus_sel.um) begin
      w_rd_mux = bus.um_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_take           = 1'b0;
    w_capture        = 1'b0;
    w_cpu_gnt_nxt    = 1'b0;
    w_dma_gnt_nxt    = 1'b0;
    w_cpu_rvalid_nxt = 1'b0;
    w_dma_rvalid_nxt = 1'b0;
    w_dm_rd_nxt      = 1'b0;
    w_dm_wr_nxt      = 1'b0;
    w_tm_rd_nxt      = 1'b0;
    w_tm_wr_nxt      = 1'b0;
    w_um_rd_nxt      = 1'b0;
    w_um_wr_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          w_take        = 1'b1;
          w_state_nxt   = ST_ISSUE;
          w_cpu_gnt_nxt = (w_win == OWN_CPU);
          w_dma_gnt_nxt = (w_win == OWN_DMA);
          w_dm_rd_nxt   = w_win_sel.dm & ~w_win_wr;
          w_dm_wr_nxt   = w_win_sel.dm &  w_win_wr;
          w_tm_rd_nxt   = w_win_sel.tm & ~w_win_wr;
          w_tm_wr_nxt   = w_win_sel.tm &  w_win_wr;
          w_um_rd_nxt   = w_win_sel.um & ~w_win_wr;
          w_um_wr_nxt   = w_win_sel.um &  w_win_wr;
        end
      end
      ST_ISSUE: begin
        if (r_wr) begin
          w_state_nxt = ST_IDLE;
        end else begin
          // Target data is valid in the strobe cycle; capture it now.
          w_capture        = 1'b1;
          w_state_nxt      = ST_RESP;
          w_cpu_rvalid_nxt = (r_owner == OWN_CPU);
          w_dma_rvalid_nxt = (r_owner == OWN_DMA);
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= OWN_DMA;
      r_owner      <= OWN_CPU;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_cpu_gnt    <= 1'b0;
      r_dma_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_dm_rd      <= 1'b0;
      r_dm_wr      <= 1'b0;
      r_tm_rd      <= 1'b0;
      r_tm_wr      <= 1'b0;
      r_um_rd      <= 1'b0;
      r_um_wr      <= 1'b0;
    end else begin
      r_cpu_gnt    <= w_cpu_gnt_nxt;
      r_dma_gnt    <= w_dma_gnt_nxt;
      r_cpu_rvalid <= w_cpu_rvalid_nxt;
      r_dma_rvalid <= w_dma_rvalid_nxt;
      r_dm_rd      <= w_dm_rd_nxt;
      r_dm_wr      <= w_dm_wr_nxt;
      r_tm_rd      <= w_tm_rd_nxt;
      r_tm_wr      <= w_tm_wr_nxt;
      r_um_rd      <= w_um_rd_nxt;
      r_um_wr      <= w_um_wr_nxt;
      if (w_take) begin
        r_ptr   <= w_win;
        r_owner <= w_win;
        r_wr    <= w_win_wr;
        r_addr  <= w_win_addr;
        r_wdata <= w_win_wdata;
      end
      if (w_capture) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign bus.cpu_gnt    = r_cpu_gnt;
  assign bus.dma_gnt    = r_dma_gnt;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.dma_rvalid = r_dma_rvalid;
  assign bus.rdata      = r_rdata;
  assign bus.bus_addr   = r_addr;
  assign bus.bus_wdata  = r_wdata;
  assign bus.dm_rd      = r_dm_rd;
  assign bus.dm_wr      = r_dm_wr;
  assign bus.tm_rd      = r_tm_rd;
  assign bus.tm_wr      = r_tm_wr;
  assign bus.um_rd      = r_um_rd;
  assign bus.um_wr      = r_um_wr;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.PER_BIT(30), .TM_LIMIT(8'h15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t cq[$];
  txn_t dq[$];

  // Per-cycle expectations filled in by the transaction-level model.
  logic [1:0]  e_gnt  [MAXC];
  logic [5:0]  e_strb [MAXC];
  logic [1:0]  e_rv   [MAXC];
  int          e_src  [MAXC];
  logic [31:0] e_baddr[MAXC];
  logic [31:0] e_bwd  [MAXC];
  logic [31:0] h_data [MAXC][3];
  logic        h_rst  [MAXC];

  int          cyc     = 0;
  int          free_at = 0;
  int          m_ptr   = 1;      // last owner: 0 CPU, 1 DMA
  logic [31:0] m_rdata = '0;
  bit          fixed   = 1'b0;
  logic [31:0] fx[3];
  int          obs_gnt[$];

  // 0 data memory, 1 timer, 2 UART
  function automatic int src_of(input logic [31:0] a);
    if (a[30] == 1'b0) return 0;
    if (a[7:0] < 8'h15) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[30] = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0: a[7:0] = 8'h14;
      1: a[7:0] = 8'h15;
      default: ;
    endcase
    return a;
  endfunction

  task automatic step(input logic rst_in);
    logic [5:0]  got_s;
    logic        cr, dr;
    int          w, s;
    txn_t        t;
    @(negedge clk);
    if (cyc + 3 >= MAXC) begin
      $display("FAIL cycle_budget: got=%0d exp<%0d", cyc, MAXC - 3);
      $fatal(1, "cycle budget exhausted");
    end
    // Outputs of cycle cyc against expectations.
    if (cyc > 0 && h_rst[cyc-1]) begin
      m_rdata = '0;
      chk("rst_bus_addr", bus.bus_addr, 32'h0);
      chk("rst_bus_wdata", bus.bus_wdata, 32'h0);
    end
    if (e_rv[cyc] != 2'b00) m_rdata = h_data[cyc-1][e_src[cyc]];
    got_s = {bus.dm_rd, bus.dm_wr, bus.tm_rd, bus.tm_wr, bus.um_rd, bus.um_wr};
    chk("gnt", {30'd0, bus.dma_gnt, bus.cpu_gnt}, {30'd0, e_gnt[cyc]});
    chk("strobe", {26'd0, got_s}, {26'd0, e_strb[cyc]});
    chk("rvalid", {30'd0, bus.dma_rvalid, bus.cpu_rvalid}, {30'd0, e_rv[cyc]});
    chk("rdata", bus.rdata, m_rdata);
    if (e_strb[cyc] != 6'd0) begin
      chk("bus_addr", bus.bus_addr, e_baddr[cyc]);
      chk("bus_wdata", bus.bus_wdata, e_bwd[cyc]);
    end
    if (bus.cpu_gnt) obs_gnt.push_back(0);
    if (bus.dma_gnt) obs_gnt.push_back(1);

    // Inputs for cycle cyc.
    reset = rst_in;
    h_rst[cyc] = rst_in;
    for (int k = 0; k < 3; k++) h_data[cyc][k] = fixed ? fx[k] : $urandom;
    bus.dm_data = h_data[cyc][0];
    bus.tm_data = h_data[cyc][1];
    bus.um_data = h_data[cyc][2];

    cr = (cq.size() > 0) && !e_gnt[cyc][0];
    dr = (dq.size() > 0) && !e_gnt[cyc][1];
    bus.cpu_req = cr;
    bus.dma_req = dr;
    if (cq.size() > 0) begin
      bus.cpu_wr = cq[0].wr; bus.cpu_addr = cq[0].addr; bus.cpu_wdata = cq[0].wdata;
    end else begin
      bus.cpu_wr = 1'($urandom); bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
    end
    if (dq.size() > 0) begin
      bus.dma_wr = dq[0].wr; bus.dma_addr = dq[0].addr; bus.dma_wdata = dq[0].wdata;
    end else begin
      bus.dma_wr = 1'($urandom); bus.dma_addr = $urandom; bus.dma_wdata = $urandom;
    end

    // Reference model: one access at a time, latency rules as plain arithmetic.
    if (rst_in) begin
      for (int k = 1; k <= 3; k++) begin
        e_gnt[cyc+k] = '0; e_strb[cyc+k] = '0; e_rv[cyc+k] = '0;
      end
      m_ptr   = 1;
      free_at = cyc + 1;
    end else if (cyc >= free_at && (cr || dr)) begin
      if (cr && dr) w = (m_ptr == 1) ? 0 : 1;
      else          w = cr ? 0 : 1;
      m_ptr = w;
      t = (w == 0) ? cq.pop_front() : dq.pop_front();
      s = src_of(t.addr);
      e_gnt[cyc+1][w]  = 1'b1;
      e_strb[cyc+1]    = 6'b100000 >> (s * 2 + (t.wr ? 1 : 0));
      e_baddr[cyc+1]   = t.addr;
      e_bwd[cyc+1]     = t.wdata;
      if (!t.wr) begin
        e_rv[cyc+2][w] = 1'b1;
        e_src[cyc+2]   = s;
        free_at        = cyc + 3;
      end else begin
        free_at        = cyc + 2;
      end
    end
    cyc++;
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    while ((cq.size() > 0 || dq.size() > 0 || cyc < free_at) && n < 300) begin
      step(1'b0);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      e_gnt[i] = '0; e_strb[i] = '0; e_rv[i] = '0; e_src[i] = 0;
      e_baddr[i] = '0; e_bwd[i] = '0; h_rst[i] = 1'b0;
    end
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_wr = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.dm_data = '0; bus.tm_data = '0; bus.um_data = '0;

    repeat (3) step(1'b1);

    // Directed accesses with fixed target data.
    fixed = 1'b1;
    fx[0] = 32'hDEAD_BEEF; fx[1] = 32'h7777_0001; fx[2] = 32'h0000_0055;
    cq.push_back('{1'b0, 32'h0000_0010, 32'h0});
    run_idle();
    chk("cpu_read_rdata", bus.rdata, 32'hDEAD_BEEF);
    cq.push_back('{1'b1, 32'h4000_0014, 32'hA1A1_0014});
    cq.push_back('{1'b1, 32'h4000_0015, 32'hB2B2_0015});
    run_idle();
    dq.push_back('{1'b0, 32'h4000_0018, 32'h0});
    run_idle();
    chk("dma_read_rdata", bus.rdata, 32'h0000_0055);

    // Both requesters pending: grants alternate starting with the CPU.
    obs_gnt.delete();
    cq.push_back('{1'b1, 32'h0000_0100, 32'h1111_1111});
    cq.push_back('{1'b0, 32'h4000_0004, 32'h0});
    dq.push_back('{1'b0, 32'h0000_0200, 32'h0});
    dq.push_back('{1'b1, 32'h4000_0030, 32'h2222_2222});
    run_idle();
    chk("tie_count", obs_gnt.size(), 32'd4);
    for (int i = 0; i < 4 && i < obs_gnt.size(); i++)
      chk("tie_order", obs_gnt[i], i % 2);

    // Reset during the ISSUE cycle of a CPU read.
    cq.push_back('{1'b0, 32'h4000_0018, 32'h0});
    step(1'b0);
    step(1'b1);
    repeat (4) step(1'b0);
    obs_gnt.delete();
    cq.push_back('{1'b1, 32'h0000_0040, 32'h3333_3333});
    dq.push_back('{1'b1, 32'h0000_0044, 32'h4444_4444});
    run_idle();
    chk("tie_after_reset", (obs_gnt.size() > 0) ? obs_gnt[0] : 99, 32'd0);

    // Randomized traffic with occasional resets.
    fixed = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (cq.size() < 3 && $urandom_range(0, 2) == 0)
        cq.push_back('{1'($urandom), rand_addr(), $urandom});
      if (dq.size() < 3 && $urandom_range(0, 2) == 0)
        dq.push_back('{1'($urandom), rand_addr(), $urandom});
      step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
    end
    run_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
